datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 clr  in  1  asynchronous active-high reset.
REQ-004 pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out  in  1 each  bus-source selects.
REQ-005 pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable, r3_enable, r4_enable, r7_enable  in  1 each  register load enables.
REQ-006 pc_increment  in  1  PC increment request.
REQ-007 read  in  1  MDR input select: 1 = m_data_in, 0 = bus.
REQ-008 op_code  in  5  ALU operation select.
REQ-009 m_data_in  in  32  memory read data.
REQ-010 bus_data  out  32  current internal bus value, for observation.
REQ-011 mar_q, ir_q  out  32 each  MAR and IR contents.

Function
REQ-012 The internal 32-bit bus SHALL be combinational: first asserted select in order pc_out, mdr_out, zhi_out, zlo_out, r3_out, r4_out, r7_out drives it; no select asserted -> 0.
REQ-013 Registers R3, R4, R7, PC, MAR, IR, Y (32-bit) SHALL each load bus_data on a rising clk when their enable is 1 and otherwise hold.
REQ-014 MDR SHALL load on a rising clk when mdr_enable=1, from m_data_in if read=1, else from bus_data.
REQ-015 When pc_increment=1, PC SHALL become PC+1 (mod 2^32) on that edge; if pc_enable is also 1, pc_enable wins.
REQ-016 The ALU SHALL be combinational, with A=Y, B=bus_data, and a 64-bit result {hi,lo}; Z (ZHI:ZLO) SHALL load the result on a rising clk when z_enable=1.
REQ-017 Opcodes 0 ld, 1 ldi, 2 st, 3 add, 12 addi SHALL produce lo=A+B; 4 sub SHALL produce lo=A-B; 5 and and 13 andi SHALL produce A&B; 6 or and 14 ori SHALL produce A|B.
REQ-018 Opcodes 7 ror, 8 rol, 9 shr (logical), 10 shra (arithmetic) and 11 shl SHALL shift A by B[4:0].
REQ-019 Opcode 16 mul SHALL produce {hi,lo} = signed A*B as the full 64-bit product.
REQ-020 Opcode 15 div SHALL produce lo = signed A/B (truncated toward zero) and hi = remainder (sign of A); B=0 SHALL give lo=0xFFFFFFFF and hi=A.
REQ-021 Opcode 17 neg SHALL produce lo=-B; opcode 18 not SHALL produce lo=~B.
REQ-022 Opcodes 19-31 SHALL produce result 0.
REQ-023 For every non-mul/div op, hi SHALL be 0.
REQ-024 Simultaneous enables SHALL all load the same bus value on the same edge.
REQ-025 A register that is both bus source and destination SHALL load its own prior value.

Reset
REQ-026 While clr=1, all registers (R3, R4, R7, PC, MAR, MDR, IR, Y, ZHI, ZLO) SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-sequence SHALL abort all loads; after release, the first rising edge SHALL behave normally.
REQ-028 After reset, bus_data SHALL be 0 when no select is asserted.

Structure
REQ-029 Opcode constants (5-bit) SHALL live in a shared package used by both RTL and bench.
REQ-030 The ALU SHALL be a separate sub-module named alu (inputs A, B, op_code; output 64-bit result); registers and bus mux SHALL be in datapath.

Verification
REQ-031 Load: m_data_in=0x22, read=1, mdr_enable=1 for one edge, then mdr_out=1, r3_enable=1 -> R3=0x00000022, bus_data=0x22 during transfer.
REQ-032 Sub: R3=0x22, R7=0x24; r3_out+y_enable; r7_out+z_enable with op_code=4; zlo_out+r4_enable -> R4=0xFFFFFFFE, ZHI=0.
REQ-033 Fetch: PC=0; pc_out+mar_enable+pc_increment one edge -> MAR=0, PC=1; mdr load 0x221B8000, then mdr_out+ir_enable -> ir_q=0x221B8000.
REQ-034 Mul: Y=0xFFFFFFFE, B=3, op 16 -> ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA; div Y=7, B=-2 -> ZLO=0xFFFFFFFD, ZHI=1; div by 0 -> ZLO=0xFFFFFFFF, ZHI=Y.
REQ-035 Reset mid-operation: assert clr between edges with R4 nonzero -> R4, PC, Z read 0 at once; no enable edge during clr changes state.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath: ALU opcode encoding and bus width.
// Imported by the RTL and the testbench so both agree on every opcode value.
package datapath_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [4:0] {
        OP_LD   = 5'd0,
        OP_LDI  = 5'd1,
        OP_ST   = 5'd2,
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,
        OP_SHR  = 5'd9,
        OP_SHRA = 5'd10,
        OP_SHL  = 5'd11,
        OP_ADDI = 5'd12,
        OP_ANDI = 5'd13,
        OP_ORI  = 5'd14,
        OP_DIV  = 5'd15,
        OP_MUL  = 5'd16,
        OP_NEG  = 5'd17,
        OP_NOT  = 5'd18
    } op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result {hi, lo}.
// Only mul and div ever drive the high word.
module alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [4:0]          op_code,
    output logic [2*DATA_W-1:0] result
);

    logic [4:0]          shamt;
    logic [5:0]          shamtInv;
    logic signed [63:0]  aExt;
    logic signed [63:0]  bExt;
    logic [63:0]         product;
    logic [31:0]         aMag;
    logic [31:0]         bMag;
    logic [31:0]         qMag;
    logic [31:0]         rMag;
    logic [31:0]         quot;
    logic [31:0]         rem;

    assign shamt    = B[4:0];
    assign shamtInv = 6'd32 - {1'b0, shamt};

    assign aExt    = {{32{A[31]}}, A};
    assign bExt    = {{32{B[31]}}, B};
    assign product = aExt * bExt;

    // Divide on magnitudes so INT_MIN / -1 wraps deterministically instead of trapping.
    assign aMag = A[31] ? (~A + 32'd1) : A;
    assign bMag = B[31] ? (~B + 32'd1) : B;
    assign qMag = (bMag == 32'd0) ? 32'd0 : (aMag / bMag);
    assign rMag = (bMag == 32'd0) ? 32'd0 : (aMag % bMag);
    assign quot = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
    assign rem  = A[31] ? (~rMag + 32'd1) : rMag;

    always_comb begin
        result = '0;
        case (op_code)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result[31:0] = A + B;
            OP_SUB:            result[31:0] = A - B;
            OP_AND, OP_ANDI:   result[31:0] = A & B;
            OP_OR, OP_ORI:     result[31:0] = A | B;
            OP_ROR:            result[31:0] = (A >> shamt) | (A << shamtInv);
            OP_ROL:            result[31:0] = (A << shamt) | (A >> shamtInv);
            OP_SHR:            result[31:0] = A >> shamt;
            OP_SHRA:           result[31:0] = $signed(A) >>> shamt;
            OP_SHL:            result[31:0] = A << shamt;
            OP_MUL:            result       = product;
            OP_DIV: begin
                if (B == 32'd0) begin
                    result = {A, 32'hFFFF_FFFF};
                end else begin
                    result = {rem, quot};
                end
            end
            OP_NEG:            result[31:0] = ~B + 32'd1;
            OP_NOT:            result[31:0] = ~B;
            default:           result       = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file slice, PC, MAR/MDR, IR, Y/Z and the
// prioritised bus mux feeding the ALU and every register input.
module datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              pc_out,
    input  logic              zlo_out,
    input  logic              zhi_out,
    input  logic              mdr_out,
    input  logic              r3_out,
    input  logic              r4_out,
    input  logic              r7_out,
    input  logic              pc_enable,
    input  logic              mar_enable,
    input  logic              mdr_enable,
    input  logic              ir_enable,
    input  logic              y_enable,
    input  logic              z_enable,
    input  logic              r3_enable,
    input  logic              r4_enable,
    input  logic              r7_enable,
    input  logic              pc_increment,
    input  logic              read,
    input  logic [4:0]        op_code,
    input  logic [DATA_W-1:0] m_data_in,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] mar_q,
    output logic [DATA_W-1:0] ir_q
);

    logic [DATA_W-1:0]   r3_q, r3_d;
    logic [DATA_W-1:0]   r4_q, r4_d;
    logic [DATA_W-1:0]   r7_q, r7_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [DATA_W-1:0]   zhi_q, zhi_d;
    logic [DATA_W-1:0]   zlo_q, zlo_d;
    logic [DATA_W-1:0]   mar_d;
    logic [DATA_W-1:0]   ir_d;
    logic [2*DATA_W-1:0] aluResult;

    // Earlier selects win when several sources are asserted at once.
    always_comb begin
        bus_data = '0;
        if (pc_out)        bus_data = pc_q;
        else if (mdr_out)  bus_data = mdr_q;
        else if (zhi_out)  bus_data = zhi_q;
        else if (zlo_out)  bus_data = zlo_q;
        else if (r3_out)   bus_data = r3_q;
        else if (r4_out)   bus_data = r4_q;
        else if (r7_out)   bus_data = r7_q;
    end

    alu u_alu (
        .A       (y_q),
        .B       (bus_data),
        .op_code (op_code),
        .result  (aluResult)
    );

    always_comb begin
        r3_d  = r3_enable  ? bus_data : r3_q;
        r4_d  = r4_enable  ? bus_data : r4_q;
        r7_d  = r7_enable  ? bus_data : r7_q;
        mar_d = mar_enable ? bus_data : mar_q;
        ir_d  = ir_enable  ? bus_data : ir_q;
        y_d   = y_enable   ? bus_data : y_q;
        mdr_d = mdr_enable ? (read ? m_data_in : bus_data) : mdr_q;
        {zhi_d, zlo_d} = z_enable ? aluResult : {zhi_q, zlo_q};
        // An explicit PC load overrides the increment request.
        if (pc_enable) begin
            pc_d = bus_data;
        end else if (pc_increment) begin
            pc_d = pc_q + 32'd1;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r3_q  <= '0;
            r4_q  <= '0;
            r7_q  <= '0;
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
        end else begin
            r3_q  <= r3_d;
            r4_q  <= r4_d;
            r7_q  <= r7_d;
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed register-transfer sequences plus
// randomized ALU operations scored against an arithmetic reference model.
module tb_datapath;
    import datapath_pkg::*;

    localparam int SEL_PC  = 0;
    localparam int SEL_MDR = 1;
    localparam int SEL_ZHI = 2;
    localparam int SEL_ZLO = 3;
    localparam int SEL_R3  = 4;
    localparam int SEL_R4  = 5;
    localparam int SEL_R7  = 6;

    logic        clk;
    logic        clr;
    logic        pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out;
    logic        pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
    logic        r3_enable, r4_enable, r7_enable;
    logic        pc_increment;
    logic        read;
    logic [4:0]  op_code;
    logic [31:0] m_data_in;
    logic [31:0] bus_data;
    logic [31:0] mar_q;
    logic [31:0] ir_q;

    int vectors;
    int miscompares;

    datapath dut (
        .clk          (clk),
        .clr          (clr),
        .pc_out       (pc_out),
        .zlo_out      (zlo_out),
        .zhi_out      (zhi_out),
        .mdr_out      (mdr_out),
        .r3_out       (r3_out),
        .r4_out       (r4_out),
        .r7_out       (r7_out),
        .pc_enable    (pc_enable),
        .mar_enable   (mar_enable),
        .mdr_enable   (mdr_enable),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .z_enable     (z_enable),
        .r3_enable    (r3_enable),
        .r4_enable    (r4_enable),
        .r7_enable    (r7_enable),
        .pc_increment (pc_increment),
        .read         (read),
        .op_code      (op_code),
        .m_data_in    (m_data_in),
        .bus_data     (bus_data),
        .mar_q        (mar_q),
        .ir_q         (ir_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU built from plain 64-bit signed arithmetic.
    function automatic logic [63:0] aluModel(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint     sa;
        longint     sb;
        int         n;
        logic [63:0] aa;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        aa = {a, a};
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: return {32'h0, a + b};
            OP_SUB:          return {32'h0, a - b};
            OP_AND, OP_ANDI: return {32'h0, a & b};
            OP_OR, OP_ORI:   return {32'h0, a | b};
            OP_ROR: begin t = aa >> n; return {32'h0, t[31:0]}; end
            OP_ROL: begin t = aa << n; return {32'h0, t[63:32]}; end
            OP_SHR:  return {32'h0, a >> n};
            OP_SHRA: begin t = sa >>> n; return {32'h0, t[31:0]}; end
            OP_SHL:  return {32'h0, a << n};
            OP_MUL:  begin t = sa * sb; return t; end
            OP_DIV: begin
                logic [63:0] q;
                logic [63:0] r;
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_NEG:  return {32'h0, 32'd0 - b};
            OP_NOT:  return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic clearControls();
        pc_out = 0; zlo_out = 0; zhi_out = 0; mdr_out = 0; r3_out = 0; r4_out = 0; r7_out = 0;
        pc_enable = 0; mar_enable = 0; mdr_enable = 0; ir_enable = 0; y_enable = 0;
        z_enable = 0; r3_enable = 0; r4_enable = 0; r7_enable = 0;
        pc_increment = 0; read = 0; op_code = 5'd0;
    endtask

    // Clock one edge with the controls currently driven, then drop them.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearControls();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setSelect(input int sel, input logic v);
        case (sel)
            SEL_PC:  pc_out  = v;
            SEL_MDR: mdr_out = v;
            SEL_ZHI: zhi_out = v;
            SEL_ZLO: zlo_out = v;
            SEL_R3:  r3_out  = v;
            SEL_R4:  r4_out  = v;
            default: r7_out  = v;
        endcase
    endtask

    task automatic checkReg(input string tag, input int sel, input logic [31:0] expected);
        setSelect(sel, 1'b1);
        #1;
        checkOutput(tag, bus_data, expected);
        setSelect(sel, 1'b0);
        #1;
    endtask

    task automatic loadMdr(input logic [31:0] value);
        m_data_in = value; read = 1; mdr_enable = 1;
        applyStimulus();
    endtask

    task automatic runAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        loadMdr(a);
        mdr_out = 1; y_enable = 1;
        applyStimulus();
        loadMdr(b);
        mdr_out = 1; z_enable = 1; op_code = op;
        applyStimulus();
    endtask

    initial begin
        logic [63:0] expZ;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        vectors = 0;
        miscompares = 0;
        m_data_in = '0;
        clearControls();

        clr = 1;
        #3;
        checkOutput("reset_bus_idle", bus_data, 32'h0);
        checkOutput("reset_mar", mar_q, 32'h0);
        checkOutput("reset_ir", ir_q, 32'h0);
        checkReg("reset_pc", SEL_PC, 32'h0);
        checkReg("reset_r4", SEL_R4, 32'h0);
        checkReg("reset_zhi", SEL_ZHI, 32'h0);
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
        $display("[TB] reset released");

        // Memory load into R3 via MDR
        loadMdr(32'h22);
        mdr_out = 1; r3_enable = 1;
        #1;
        checkOutput("load_bus_during_xfer", bus_data, 32'h22);
        applyStimulus();
        checkReg("load_r3", SEL_R3, 32'h22);

        // Subtract R3 - R7 into R4
        loadMdr(32'h24);
        mdr_out = 1; r7_enable = 1;
        applyStimulus();
        r3_out = 1; y_enable = 1;
        applyStimulus();
        r7_out = 1; z_enable = 1; op_code = OP_SUB;
        applyStimulus();
        zlo_out = 1; r4_enable = 1;
        applyStimulus();
        checkReg("sub_r4", SEL_R4, 32'hFFFF_FFFE);
        checkReg("sub_zhi", SEL_ZHI, 32'h0);

        // Instruction fetch
        pc_out = 1; mar_enable = 1; pc_increment = 1;
        applyStimulus();
        checkOutput("fetch_mar", mar_q, 32'h0);
        checkReg("fetch_pc", SEL_PC, 32'h1);
        loadMdr(32'h221B_8000);
        mdr_out = 1; ir_enable = 1;
        applyStimulus();
        checkOutput("fetch_ir", ir_q, 32'h221B_8000);

        // Directed mul/div corner cases
        runAlu(OP_MUL, 32'hFFFF_FFFE, 32'd3);
        checkReg("mul_zhi", SEL_ZHI, 32'hFFFF_FFFF);
        checkReg("mul_zlo", SEL_ZLO, 32'hFFFF_FFFA);
        runAlu(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        checkReg("div_zlo", SEL_ZLO, 32'hFFFF_FFFD);
        checkReg("div_zhi", SEL_ZHI, 32'h1);
        runAlu(OP_DIV, 32'h1234_5678, 32'd0);
        checkReg("div0_zlo", SEL_ZLO, 32'hFFFF_FFFF);
        checkReg("div0_zhi", SEL_ZHI, 32'h1234_5678);
        runAlu(OP_ROR, 32'h0000_0001, 32'd1);
        checkReg("ror_zlo", SEL_ZLO, 32'h8000_0000);
        runAlu(OP_SHRA, 32'h8000_0000, 32'd4);
        checkReg("shra_zlo", SEL_ZLO, 32'hF800_0000);
        runAlu(5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkReg("unused_op_zlo", SEL_ZLO, 32'h0);

        // PC load beats increment, then increment alone
        loadMdr(32'h100);
        mdr_out = 1; pc_enable = 1; pc_increment = 1;
        applyStimulus();
        checkReg("pc_load_wins", SEL_PC, 32'h100);
        pc_increment = 1;
        applyStimulus();
        checkReg("pc_increment", SEL_PC, 32'h101);

        // Bus priority
        pc_out = 1; mdr_out = 1;
        #1;
        checkOutput("prio_pc_over_mdr", bus_data, 32'h101);
        clearControls();
        zhi_out = 1; zlo_out = 1; r3_out = 1;
        #1;
        checkOutput("prio_zhi_over_zlo", bus_data, 32'h0);
        clearControls();
        #1;

        // Simultaneous loads and self-source
        loadMdr(32'hCAFE_0001);
        mdr_out = 1; r3_enable = 1; r4_enable = 1; r7_enable = 1;
        applyStimulus();
        checkReg("multi_r3", SEL_R3, 32'hCAFE_0001);
        checkReg("multi_r7", SEL_R7, 32'hCAFE_0001);
        loadMdr(32'h5);
        r4_out = 1; r4_enable = 1; r3_enable = 1;
        applyStimulus();
        checkReg("self_r4", SEL_R4, 32'hCAFE_0001);
        checkReg("self_copy_r3", SEL_R3, 32'hCAFE_0001);

        // Randomized ALU operations
        for (int i = 0; i < 150; i++) begin
            a  = $urandom;
            op = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 40));
                1: b = 32'd0 - 32'($urandom_range(0, 40));
                2: b = 32'd0;
                default: b = $urandom;
            endcase
            runAlu(op, a, b);
            expZ = aluModel(op, a, b);
            checkReg($sformatf("rand_zlo_op%0d", op), SEL_ZLO, expZ[31:0]);
            checkReg($sformatf("rand_zhi_op%0d", op), SEL_ZHI, expZ[63:32]);
        end

        // Reset asserted mid-cycle with loads pending
        m_data_in = 32'h0000_ABCD; read = 1; mdr_enable = 1;
        pc_increment = 1; r4_enable = 1; z_enable = 1;
        #3;
        clr = 1;
        #1;
        checkReg("midrst_r4", SEL_R4, 32'h0);
        checkReg("midrst_pc", SEL_PC, 32'h0);
        checkReg("midrst_zlo", SEL_ZLO, 32'h0);
        checkReg("midrst_zhi", SEL_ZHI, 32'h0);
        @(posedge clk);
        #1;
        checkReg("midrst_pc_held", SEL_PC, 32'h0);
        checkReg("midrst_mdr_held", SEL_MDR, 32'h0);
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
        checkReg("postrst_mdr", SEL_MDR, 32'h0000_ABCD);
        checkReg("postrst_pc", SEL_PC, 32'h1);
        clearControls();
        #1;
        checkOutput("postrst_bus_idle", bus_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
